// File: rtl/synth_gen_controller.sv
// Top-level sequencer for the phase-accumulator datapath: validates host configs,
// holds shadow config stable and runs single, repeated or continuous packet trains.
`timescale 1ns/1ps
module synth_gen_controller #(
    parameter int unsigned NUM_SIGNAL_TYPES = 3,
    parameter logic [31:0] F_CARRIER_MAX    = 32'd4000000000,
    parameter logic [15:0] START_TIMEOUT    = 16'd64,
    parameter int unsigned ABORT_CYCLES     = 2,
    parameter int unsigned MIN_GAP          = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CFG_VALID,
    output logic        CFG_READY,
    input  logic [1:0]  CFG_SIGNAL_TYPE,
    input  logic [31:0] CFG_F_CARRIER,
    input  logic [9:0]  CFG_T_IMPULSE,
    input  logic [12:0] CFG_T_PERIOD,
    input  logic [4:0]  CFG_NUM_OF_IMP,
    input  logic [7:0]  CFG_REPEAT_CNT,
    input  logic [15:0] CFG_GAP_CYCLES,
    input  logic        CMD_START,
    input  logic        CMD_STOP,
    input  logic        OUT_REG_READY,
    input  logic        SIGN_START_CALC,
    input  logic        SIGN_STOP_CALC,
    output logic [1:0]  SIGNAL_TYPE,
    output logic [31:0] F_CARRIER,
    output logic [9:0]  T_IMPULSE,
    output logic [12:0] T_PERIOD,
    output logic [4:0]  NUM_OF_IMP,
    output logic        SIGN_START_GEN,
    output logic        ACC_RESET,
    output logic        BUSY,
    output logic        DONE,
    output logic [1:0]  ERR,
    output logic [7:0]  PKT_CNT
);

    localparam logic [7:0]  LP_ABORT_LAST = 8'(ABORT_CYCLES - 1);
    localparam logic [15:0] LP_MIN_GAP    = 16'(MIN_GAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_ARMED,
        S_RUNNING,
        S_GAP,
        S_ABORT
    } state_t;

    state_t      r_state;
    logic        r_cfgReady;
    logic        r_cfgOk;
    logic [1:0]  r_sigType;
    logic [31:0] r_fCarrier;
    logic [9:0]  r_tImpulse;
    logic [12:0] r_tPeriod;
    logic [4:0]  r_numOfImp;
    logic [7:0]  r_repeatCnt;
    logic [15:0] r_gapCycles;
    logic        r_startGen;
    logic        r_accReset;
    logic        r_busy;
    logic        r_done;
    logic [1:0]  r_err;
    logic [7:0]  r_pktCnt;
    logic [15:0] r_tmoCnt;
    logic [15:0] r_gapCnt;
    logic [7:0]  r_abortCnt;

    logic        w_accept;
    logic        w_typeOk;
    logic        w_freqOk;
    logic        w_timeOk;
    logic        w_cfgLegal;
    logic [7:0]  w_pktNext;
    logic [15:0] w_gapLoad;

    assign w_accept   = CFG_VALID && r_cfgReady;
    assign w_typeOk   = {30'd0, CFG_SIGNAL_TYPE} < NUM_SIGNAL_TYPES;
    assign w_freqOk   = (CFG_F_CARRIER != 32'd0) && (CFG_F_CARRIER <= F_CARRIER_MAX);
    assign w_timeOk   = (CFG_T_IMPULSE != 10'd0) && (CFG_NUM_OF_IMP != 5'd0) &&
                        ((CFG_NUM_OF_IMP <= 5'd1) || ({3'd0, CFG_T_IMPULSE} < CFG_T_PERIOD));
    assign w_cfgLegal = w_typeOk && w_freqOk && w_timeOk;
    assign w_pktNext  = r_pktCnt + 8'd1;
    assign w_gapLoad  = (r_gapCycles > LP_MIN_GAP) ? r_gapCycles : LP_MIN_GAP;

    // Abort has priority over every other transition once a run is under way.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_cfgReady  <= 1'b0;
            r_cfgOk     <= 1'b0;
            r_sigType   <= '0;
            r_fCarrier  <= '0;
            r_tImpulse  <= '0;
            r_tPeriod   <= '0;
            r_numOfImp  <= '0;
            r_repeatCnt <= '0;
            r_gapCycles <= '0;
            r_startGen  <= 1'b0;
            r_accReset  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 2'b00;
            r_pktCnt    <= '0;
            r_tmoCnt    <= '0;
            r_gapCnt    <= '0;
            r_abortCnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (CMD_STOP && (r_state != S_IDLE) && (r_state != S_ABORT)) begin
                r_startGen <= 1'b0;
                r_accReset <= 1'b1;
                r_abortCnt <= '0;
                r_err      <= 2'b11;
                r_state    <= S_ABORT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cfgReady <= 1'b1;
                        if (w_accept) begin
                            if (w_cfgLegal) begin
                                r_sigType   <= CFG_SIGNAL_TYPE;
                                r_fCarrier  <= CFG_F_CARRIER;
                                r_tImpulse  <= CFG_T_IMPULSE;
                                r_tPeriod   <= CFG_T_PERIOD;
                                r_numOfImp  <= CFG_NUM_OF_IMP;
                                r_repeatCnt <= CFG_REPEAT_CNT;
                                r_gapCycles <= CFG_GAP_CYCLES;
                                r_cfgOk     <= 1'b1;
                                r_err       <= 2'b00;
                            end else begin
                                r_err <= 2'b01;
                            end
                        end else if (CMD_START) begin
                            if (r_cfgOk) begin
                                r_busy     <= 1'b1;
                                r_err      <= 2'b00;
                                r_pktCnt   <= '0;
                                r_cfgReady <= 1'b0;
                                r_state    <= S_WAIT_READY;
                            end else begin
                                r_err <= 2'b01;
                            end
                        end
                    end
                    S_WAIT_READY: begin
                        if (OUT_REG_READY) begin
                            r_startGen <= 1'b1;
                            r_tmoCnt   <= '0;
                            r_state    <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (SIGN_START_CALC) begin
                            r_startGen <= 1'b0;
                            r_state    <= S_RUNNING;
                        end else if (r_tmoCnt == START_TIMEOUT - 16'd1) begin
                            r_startGen <= 1'b0;
                            r_accReset <= 1'b1;
                            r_abortCnt <= '0;
                            r_err      <= 2'b10;
                            r_state    <= S_ABORT;
                        end else begin
                            r_tmoCnt <= r_tmoCnt + 16'd1;
                        end
                    end
                    S_RUNNING: begin
                        if (SIGN_STOP_CALC) begin
                            r_pktCnt <= w_pktNext;
                            if ((r_repeatCnt != 8'd0) && (w_pktNext == r_repeatCnt)) begin
                                r_done     <= 1'b1;
                                r_busy     <= 1'b0;
                                r_cfgReady <= 1'b1;
                                r_state    <= S_IDLE;
                            end else begin
                                r_gapCnt <= w_gapLoad;
                                r_state  <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (r_gapCnt <= 16'd1) begin
                            r_state <= S_WAIT_READY;
                        end else begin
                            r_gapCnt <= r_gapCnt - 16'd1;
                        end
                    end
                    S_ABORT: begin
                        if (r_abortCnt == LP_ABORT_LAST) begin
                            r_accReset <= 1'b0;
                            r_busy     <= 1'b0;
                            r_cfgReady <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_abortCnt <= r_abortCnt + 8'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign CFG_READY      = r_cfgReady;
    assign SIGNAL_TYPE    = r_sigType;
    assign F_CARRIER      = r_fCarrier;
    assign T_IMPULSE      = r_tImpulse;
    assign T_PERIOD       = r_tPeriod;
    assign NUM_OF_IMP     = r_numOfImp;
    assign SIGN_START_GEN = r_startGen;
    assign ACC_RESET      = r_accReset;
    assign BUSY           = r_busy;
    assign DONE           = r_done;
    assign ERR            = r_err;
    assign PKT_CNT        = r_pktCnt;

endmodule
